kinase_valve_sequencer: RTL and testbench
=========================================

KINASE_VALVE_SEQUENCER -- requirements
Module: kinase_valve_sequencer

Interface
REQ-001 The block SHALL have parameter PUMP_DIV, default 4, giving the clock cycles each peristaltic phase is held (legal range 1..255).
REQ-002 The block SHALL have parameter DUR_W, default 16, giving the step-duration field width.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 step_valid  input  1  host presents a step word.
REQ-006 step_ctrl  input  13  levels for control valves c1..c13 (bit0 = c1); 1 = pressurized/closed.
REQ-007 step_sieve  input  4  levels for sieve valves s1..s4.
REQ-008 step_pump  input  5  static levels for pump valves p1..p5.
REQ-009 step_pump_en  input  1  run the peristaltic pattern on p1..p3 for this step.
REQ-010 step_dur  input  DUR_W  hold time in cycles; 0 is treated as 1.
REQ-011 abort  input  1  synchronous abort request.
REQ-012 step_ready  output  1  block accepts a step this cycle.
REQ-013 c  output  13  control valve drive to c1..c13.
REQ-014 s  output  4  sieve valve drive to s1..s4.
REQ-015 p  output  5  pump valve drive to p1..p5.
REQ-016 busy  output  1  a step is executing.
REQ-017 step_done  output  1  one-cycle pulse in the last cycle of each step.
REQ-018 step_count  output  8  steps completed since reset; wraps 255 -> 0.

Function
REQ-019 FSM SHALL have two states: IDLE and RUN.
REQ-020 step_ready SHALL equal !abort && (IDLE || (RUN && remaining == 1)).
REQ-021 Accept SHALL occur when step_valid && step_ready; fields are registered at acceptance.
REQ-022 Outputs c, s, p SHALL take the new step's values on the cycle after acceptance and hold them for exactly max(step_dur,1) cycles.
REQ-023 The remaining counter SHALL load max(step_dur,1) at acceptance and decrement once per RUN cycle.
REQ-024 step_done SHALL pulse when RUN && remaining == 1 && !abort; step_count SHALL increment on the same edge.
REQ-025 Back-to-back accept in the last RUN cycle SHALL give zero-bubble transitions: RUN continues and the new values appear on the next cycle.
REQ-026 RUN -> IDLE SHALL occur when the last cycle passes without an accept; in IDLE, c, s and p SHALL hold the last step's levels, with p1..p3 taken from step_pump.
REQ-027 When step_pump_en = 1, p[2:0] SHALL cycle through the phase pattern 001, 011, 010, 110, 100, 101 (p1 = bit0), holding each phase PUMP_DIV cycles.
REQ-028 The phase SHALL start at phase 0 on every accepted step and wrap from phase 5 to phase 0.
REQ-029 Under pumping, p[4:3] SHALL come from step_pump[4:3].
REQ-030 When step_pump_en = 0, p SHALL equal step_pump.
REQ-031 abort SHALL take priority over accept and completion: next cycle c = s = p = 0, state IDLE, counters cleared, no step_done, and step_count unchanged.
REQ-032 busy SHALL be 1 exactly when the state is RUN.

Reset
REQ-033 On rst, the block SHALL set state IDLE, c = 0, s = 0, p = 0, busy = 0, step_done = 0, step_count = 0, the remaining counter to 0 and the phase to 0; step_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-034 Reset mid-step SHALL discard the step; rst SHALL have priority over abort and accept.

Verification
REQ-035 Bench SHALL cover: single step ctrl = 0x0005, sieve = 0x3, dur = 3 -> c = 0x0005 for exactly 3 cycles, step_done in the 3rd cycle, step_count = 1, then IDLE holding the levels.
REQ-036 Bench SHALL cover: step_dur = 0 -> step behaves as dur = 1, with one step_done.
REQ-037 Bench SHALL cover: two steps with step_valid held high, dur = 2 each -> no gap between them, c changes on the 3rd cycle, two step_done pulses.
REQ-038 Bench SHALL cover: PUMP_DIV = 2, pump_en = 1, dur = 12 -> p[2:0] sequence 001,001,011,011,010,010,110,110,100,100,101,101.
REQ-039 Bench SHALL cover: abort in cycle 2 of a dur = 10 step, with step_valid also high -> outputs all 0 next cycle, IDLE, no accept, step_count unchanged.
REQ-040 Bench SHALL cover: rst during RUN, then 256 completed steps -> all outputs 0 after reset, then step_count wraps to 0.

Source files
------------

// File: rtl/kinase_valve_sequencer_if.sv
// Host-side step bus and valve drive outputs of the kinase valve sequencer.
// The host owns the step word and abort; the sequencer owns the valve levels and status.
interface kinase_valve_sequencer_if #(
    parameter int DUR_W = 16
);
    logic             step_valid;
    logic [12:0]      step_ctrl;
    logic [3:0]       step_sieve;
    logic [4:0]       step_pump;
    logic             step_pump_en;
    logic [DUR_W-1:0] step_dur;
    logic             abort;
    logic             step_ready;
    logic [12:0]      c;
    logic [3:0]       s;
    logic [4:0]       p;
    logic             busy;
    logic             step_done;
    logic [7:0]       step_count;

    modport master (
        output step_valid, step_ctrl, step_sieve, step_pump, step_pump_en, step_dur, abort,
        input  step_ready, c, s, p, busy, step_done, step_count
    );

    modport slave (
        input  step_valid, step_ctrl, step_sieve, step_pump, step_pump_en, step_dur, abort,
        output step_ready, c, s, p, busy, step_done, step_count
    );
endinterface

// File: rtl/kinase_valve_sequencer.sv
// Microfluidic valve sequencer: holds each step's valve levels for its duration and
// optionally runs a six-phase peristaltic pattern on p1..p3.
module kinase_valve_sequencer #(
    parameter int PUMP_DIV = 4,
    parameter int DUR_W    = 16
) (
    input logic                      clk,
    input logic                      rst,
    kinase_valve_sequencer_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0]       DIV_LAST = 8'(PUMP_DIV - 1);
    localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

    state_t           state;
    logic [DUR_W-1:0] remaining;
    logic [7:0]       div_cnt;
    logic [2:0]       phase;
    logic [4:0]       pump_r;
    logic             pump_en_r;
    logic [12:0]      c_r;
    logic [3:0]       s_r;
    logic [4:0]       p_r;
    logic [7:0]       count_r;

    logic             last;
    logic             ready;
    logic             accept;
    logic             done;
    logic [2:0]       phase_nxt;
    logic [DUR_W-1:0] dur_load;

    function automatic logic [2:0] pattern(input logic [2:0] ph);
        case (ph)
            3'd0:    pattern = 3'b001;
            3'd1:    pattern = 3'b011;
            3'd2:    pattern = 3'b010;
            3'd3:    pattern = 3'b110;
            3'd4:    pattern = 3'b100;
            default: pattern = 3'b101;
        endcase
    endfunction

    assign last      = (state == RUN) && (remaining == DUR_ONE);
    assign ready     = !bus.abort && ((state == IDLE) || last);
    assign accept    = bus.step_valid && ready;
    assign done      = last && !bus.abort;
    assign dur_load  = (bus.step_dur == '0) ? DUR_ONE : bus.step_dur;
    // Phase advances on the cycle that finishes the current PUMP_DIV hold window.
    assign phase_nxt = (div_cnt != DIV_LAST) ? phase :
                       (phase == 3'd5)       ? 3'd0  : phase + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            div_cnt   <= '0;
            phase     <= '0;
            pump_r    <= '0;
            pump_en_r <= 1'b0;
            c_r       <= '0;
            s_r       <= '0;
            p_r       <= '0;
            count_r   <= '0;
        end else if (bus.abort) begin
            state     <= IDLE;
            remaining <= '0;
            div_cnt   <= '0;
            phase     <= '0;
            pump_r    <= '0;
            pump_en_r <= 1'b0;
            c_r       <= '0;
            s_r       <= '0;
            p_r       <= '0;
        end else begin
            if (done)
                count_r <= count_r + 8'd1;
            if (accept) begin
                state     <= RUN;
                remaining <= dur_load;
                div_cnt   <= '0;
                phase     <= '0;
                pump_r    <= bus.step_pump;
                pump_en_r <= bus.step_pump_en;
                c_r       <= bus.step_ctrl;
                s_r       <= bus.step_sieve;
                p_r       <= bus.step_pump_en ? {bus.step_pump[4:3], pattern(3'd0)} : bus.step_pump;
            end else if (last) begin
                // Idle keeps the step's levels, with p1..p3 back on their static values.
                state     <= IDLE;
                remaining <= '0;
                div_cnt   <= '0;
                phase     <= '0;
                p_r       <= pump_r;
            end else if (state == RUN) begin
                remaining <= remaining - DUR_ONE;
                div_cnt   <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
                phase     <= phase_nxt;
                if (pump_en_r)
                    p_r[2:0] <= pattern(phase_nxt);
            end
        end
    end

    assign bus.step_ready = ready;
    assign bus.step_done  = done;
    assign bus.busy       = (state == RUN);
    assign bus.c          = c_r;
    assign bus.s          = s_r;
    assign bus.p          = p_r;
    assign bus.step_count = count_r;
endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Directed and randomized checks of kinase_valve_sequencer against a step-level reference model.
module tb_kinase_valve_sequencer;
    localparam int PD = 2;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kinase_valve_sequencer_if #(.DUR_W(DW)) bus ();
    kinase_valve_sequencer #(.PUMP_DIV(PD), .DUR_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int fails  = 0;
    int done_seen = 0;

    // Reference model: current step record plus elapsed-cycle index within it.
    logic        m_busy;
    logic [12:0] m_ctrl;
    logic [3:0]  m_sieve;
    logic [4:0]  m_pump;
    logic        m_en;
    int          m_dur, m_t;
    logic [12:0] m_c;
    logic [3:0]  m_s;
    logic [4:0]  m_p;
    logic [7:0]  m_count;
    logic [2:0]  pat [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_ctrl = 0; m_sieve = 0; m_pump = 0; m_en = 0;
        m_dur = 0; m_t = 0; m_c = 0; m_s = 0; m_p = 0; m_count = 0;
    endtask

    task automatic set_step(input logic v, input logic [12:0] ctrl, input logic [3:0] sieve,
                            input logic [4:0] pump, input logic en, input logic [15:0] dur);
        bus.step_valid   = v;
        bus.step_ctrl    = ctrl;
        bus.step_sieve   = sieve;
        bus.step_pump    = pump;
        bus.step_pump_en = en;
        bus.step_dur     = dur;
    endtask

    task automatic tick();
        logic last, ready, done, acc;
        logic [12:0] ec;
        logic [3:0]  es;
        logic [4:0]  ep;
        #1;
        last  = m_busy && (m_t == m_dur - 1);
        ready = !bus.abort && (!m_busy || last);
        done  = last && !bus.abort;
        check("step_ready", bus.step_ready, ready);
        check("step_done", bus.step_done, done);
        if (bus.step_done) done_seen++;
        acc = bus.step_valid && ready;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (bus.abort) begin
            m_busy = 0; m_c = 0; m_s = 0; m_p = 0;
        end else begin
            if (done) m_count++;
            if (acc) begin
                m_busy  = 1;
                m_ctrl  = bus.step_ctrl;
                m_sieve = bus.step_sieve;
                m_pump  = bus.step_pump;
                m_en    = bus.step_pump_en;
                m_dur   = (bus.step_dur == 0) ? 1 : int'(bus.step_dur);
                m_t     = 0;
            end else if (last) begin
                m_busy = 0; m_c = m_ctrl; m_s = m_sieve; m_p = m_pump;
            end else if (m_busy) begin
                m_t++;
            end
        end
        #1;
        if (m_busy) begin
            ec = m_ctrl; es = m_sieve;
            ep = m_en ? {m_pump[4:3], pat[(m_t / PD) % 6]} : m_pump;
        end else begin
            ec = m_c; es = m_s; ep = m_p;
        end
        check("c", bus.c, ec);
        check("s", bus.s, es);
        check("p", bus.p, ep);
        check("busy", bus.busy, m_busy);
        check("step_count", bus.step_count, m_count);
    endtask

    initial begin
        int d0, hold;
        logic [7:0] cnt0;
        logic [2:0] seq [12];
        logic [2:0] exp_seq [12] = '{3'd1, 3'd1, 3'd3, 3'd3, 3'd2, 3'd2, 3'd6, 3'd6, 3'd4, 3'd4, 3'd5, 3'd5};

        set_step(0, 0, 0, 0, 0, 0);
        bus.abort = 0;
        model_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check("rst_c", bus.c, 0);
        check("rst_s", bus.s, 0);
        check("rst_p", bus.p, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_count", bus.step_count, 0);
        check("rst_done", bus.step_done, 0);
        check("ready_after_rst", bus.step_ready, 1);

        // Single 3-cycle step
        d0 = done_seen; hold = 0;
        set_step(1, 13'h0005, 4'h3, 5'h00, 0, 3);
        tick();
        set_step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("s35_done_pos", bus.step_done, (i == 2));
            if (bus.c == 13'h0005 && bus.busy) hold++;
            tick();
        end
        check("s35_hold", hold, 3);
        check("s35_idle", bus.busy, 0);
        check("s35_c_held", bus.c, 13'h0005);
        check("s35_s_held", bus.s, 4'h3);
        check("s35_count", bus.step_count, 1);
        check("s35_dones", done_seen - d0, 1);
        tick();

        // Zero duration behaves as one cycle
        d0 = done_seen;
        set_step(1, 13'h1234, 4'h9, 5'h15, 0, 0);
        tick();
        check("s36_busy", bus.busy, 1);
        set_step(0, 0, 0, 0, 0, 0);
        tick();
        check("s36_idle", bus.busy, 0);
        check("s36_dones", done_seen - d0, 1);

        // Back-to-back steps with step_valid held
        d0 = done_seen;
        set_step(1, 13'h00A0, 4'h1, 5'h02, 0, 2);
        tick();
        check("s37_c1", bus.c, 13'h00A0);
        set_step(1, 13'h1F00, 4'h2, 5'h04, 0, 2);
        tick();
        check("s37_c2", bus.c, 13'h00A0);
        tick();
        check("s37_c3", bus.c, 13'h1F00);
        check("s37_busy3", bus.busy, 1);
        set_step(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("s37_idle", bus.busy, 0);
        check("s37_dones", done_seen - d0, 2);

        // Peristaltic pattern
        set_step(1, 13'h0001, 4'h0, 5'b11000, 1, 12);
        tick();
        set_step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            seq[i] = bus.p[2:0];
            check("s38_p43", bus.p[4:3], 2'b11);
            tick();
        end
        for (int i = 0; i < 12; i++) check("s38_seq", seq[i], exp_seq[i]);
        check("s38_idle_p", bus.p, 5'b11000);

        // Abort in cycle 2 with step_valid high
        cnt0 = bus.step_count;
        set_step(1, 13'h1ABC, 4'h5, 5'h0A, 0, 10);
        tick();
        set_step(1, 13'h0F0F, 4'hC, 5'h11, 0, 4);
        tick();
        bus.abort = 1;
        tick();
        check("s39_c", bus.c, 0);
        check("s39_s", bus.s, 0);
        check("s39_p", bus.p, 0);
        check("s39_busy", bus.busy, 0);
        check("s39_count", bus.step_count, cnt0);
        bus.abort = 0;
        set_step(0, 0, 0, 0, 0, 0);
        tick();
        check("s39_still_idle", bus.busy, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_step(1'($urandom_range(0, 1)), 13'($urandom), 4'($urandom), 5'($urandom),
                     1'($urandom), 16'($urandom_range(0, 13)));
            bus.abort = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        bus.abort = 0;
        rst = 0;
        set_step(0, 0, 0, 0, 0, 0);
        tick();

        // Reset mid-step, then 256 completions wrap the counter
        set_step(1, 13'h0777, 4'hF, 5'h1F, 1, 5);
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        check("s40_c", bus.c, 0);
        check("s40_s", bus.s, 0);
        check("s40_p", bus.p, 0);
        check("s40_busy", bus.busy, 0);
        check("s40_count0", bus.step_count, 0);
        d0 = done_seen;
        set_step(1, 13'h0003, 4'h1, 5'h01, 0, 1);
        for (int i = 0; i < 256; i++) tick();
        set_step(0, 0, 0, 0, 0, 0);
        tick();
        check("s40_dones", done_seen - d0, 256);
        check("s40_wrap", bus.step_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
